// File: rtl/countdown_timer_if.sv
// Control and status bundle for countdown_timer.
// master drives the controls, slave is the timer itself.
interface countdown_timer_if #(
   parameter int WIDTH = 8
);
   logic             i_load;
   logic [WIDTH-1:0] i_load_value;
   logic             i_start;
   logic             i_stop;
   logic             i_periodic;
   logic [WIDTH-1:0] o_value;
   logic             o_busy;
   logic             o_expired;

   modport master (
      output i_load, i_load_value, i_start,
      output i_stop, i_periodic,
      input  o_value, o_busy, o_expired
   );

   modport slave (
      input  i_load, i_load_value, i_start,
      input  i_stop, i_periodic,
      output o_value, o_busy, o_expired
   );
endinterface

// File: rtl/countdown_timer.sv
// Loadable prescaled down-counter with one-shot or periodic
// expiry pulse and pause/resume.
module countdown_timer #(
   parameter int MAX_VALUE = 255,
   parameter int PRESCALE  = 1
) (
   input logic i_clk,
   input logic i_s_rst_n,
   countdown_timer_if.slave tmr
);
   localparam int WIDTH = $clog2(MAX_VALUE + 1);
   localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic             expired_q, expired_d;
   logic [WIDTH-1:0] load_clamped;
   logic             running;
   logic             tick;
   logic             last;

   always_comb begin
      load_clamped = tmr.i_load_value;
      if (tmr.i_load_value > WIDTH'(MAX_VALUE))
         load_clamped = WIDTH'(MAX_VALUE);
   end

   // A run advances only when no higher-priority control is present.
   always_comb begin
      running = (state_q == RUN) && !tmr.i_load && !tmr.i_stop;
      tick    = running && (presc_q == PW'(PRESCALE - 1));
      last    = (count_q == WIDTH'(1));
   end

   always_ff @(posedge i_clk) begin
      if (!i_s_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (!tmr.i_load && !tmr.i_stop && tmr.i_start
                && count_q != '0)
               state_d = RUN;
         end
         RUN: begin
            if (tmr.i_load)
               state_d = IDLE;
            else if (tmr.i_stop)
               state_d = HOLD;
            else if (tick && last && !tmr.i_periodic)
               state_d = IDLE;
         end
         HOLD: begin
            if (tmr.i_load)
               state_d = IDLE;
            else if (!tmr.i_stop && tmr.i_start)
               state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      count_d   = count_q;
      reload_d  = reload_q;
      presc_d   = presc_q;
      expired_d = 1'b0;
      if (tmr.i_load) begin
         count_d  = load_clamped;
         reload_d = load_clamped;
         presc_d  = '0;
      end else if (state_q == IDLE && tmr.i_start
                   && !tmr.i_stop) begin
         presc_d = '0;
      end else if (running) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
         if (tick) begin
            if (last) begin
               expired_d = 1'b1;
               count_d   = tmr.i_periodic ? reload_q : '0;
            end else begin
               count_d = count_q - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_s_rst_n) begin
         count_q   <= '0;
         reload_q  <= '0;
         presc_q   <= '0;
         expired_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         reload_q  <= reload_d;
         presc_q   <= presc_d;
         expired_q <= expired_d;
      end
   end

   always_comb begin
      tmr.o_value   = count_q;
      tmr.o_busy    = (state_q == RUN);
      tmr.o_expired = expired_q;
   end
endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: two instances (255/1 and 100/4)
// checked each cycle against a cycles-to-tick model.
module tb_countdown_timer;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   countdown_timer_if #(.WIDTH(8)) ifa ();
   countdown_timer_if #(.WIDTH(7)) ifb ();

   countdown_timer #(.MAX_VALUE(255), .PRESCALE(1)) dut_a (
      .i_clk    (clk),
      .i_s_rst_n(rst_n),
      .tmr      (ifa)
   );

   countdown_timer #(.MAX_VALUE(100), .PRESCALE(4)) dut_b (
      .i_clk    (clk),
      .i_s_rst_n(rst_n),
      .tmr      (ifb)
   );

   typedef struct {
      int cnt;
      int rel;
      int left;
      bit run;
      bit hold;
      bit exp;
   } m_t;

   m_t ma, mb;
   int checks = 0;
   int errors = 0;
   bit armed  = 1'b0;

   // left = clock cycles still to elapse before the next tick
   function automatic m_t mstep(m_t m, bit rn, bit ld, int lv,
                                bit st, bit sp, bit per,
                                int maxv, int ps);
      m_t n = m;
      n.exp = 1'b0;
      if (!rn) begin
         n.cnt = 0; n.rel = 0; n.left = ps;
         n.run = 0; n.hold = 0;
      end else if (ld) begin
         n.cnt = (lv > maxv) ? maxv : lv;
         n.rel = n.cnt; n.left = ps;
         n.run = 0; n.hold = 0;
      end else if (sp) begin
         if (n.run) begin
            n.run = 0; n.hold = 1;
         end
      end else if (st && !n.run) begin
         if (n.hold) begin
            n.hold = 0; n.run = 1;
         end else if (n.cnt != 0) begin
            n.run = 1; n.left = ps;
         end
      end else if (n.run) begin
         n.left = n.left - 1;
         if (n.left == 0) begin
            n.left = ps;
            if (n.cnt == 1) begin
               n.exp = 1'b1;
               if (per) n.cnt = n.rel;
               else begin
                  n.cnt = 0; n.run = 0;
               end
            end else begin
               n.cnt = n.cnt - 1;
            end
         end
      end
      return n;
   endfunction

   always @(posedge clk) begin
      ma = mstep(ma, rst_n, ifa.i_load, int'(ifa.i_load_value),
                 ifa.i_start, ifa.i_stop, ifa.i_periodic, 255, 1);
      mb = mstep(mb, rst_n, ifb.i_load, int'(ifb.i_load_value),
                 ifb.i_start, ifb.i_stop, ifb.i_periodic, 100, 4);
   end

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (armed) begin
         chk("model_a_value", int'(ifa.o_value), ma.cnt);
         chk("model_a_busy", int'(ifa.o_busy), int'(ma.run));
         chk("model_a_exp", int'(ifa.o_expired), int'(ma.exp));
         chk("model_b_value", int'(ifb.o_value), mb.cnt);
         chk("model_b_busy", int'(ifb.o_busy), int'(mb.run));
         chk("model_b_exp", int'(ifb.o_expired), int'(mb.exp));
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic load_a(int v);
      ifa.i_load = 1'b1;
      ifa.i_load_value = 8'(v);
      cyc();
      ifa.i_load = 1'b0;
   endtask

   task automatic start_a();
      ifa.i_start = 1'b1;
      cyc();
      ifa.i_start = 1'b0;
   endtask

   task automatic load_b(int v);
      ifb.i_load = 1'b1;
      ifb.i_load_value = 7'(v);
      cyc();
      ifb.i_load = 1'b0;
   endtask

   task automatic start_b();
      ifb.i_start = 1'b1;
      cyc();
      ifb.i_start = 1'b0;
   endtask

   initial begin
      ifa.i_load = 0; ifa.i_load_value = '0; ifa.i_start = 0;
      ifa.i_stop = 0; ifa.i_periodic = 0;
      ifb.i_load = 0; ifb.i_load_value = '0; ifb.i_start = 0;
      ifb.i_stop = 0; ifb.i_periodic = 0;
      repeat (2) cyc();
      chk("rst_value", int'(ifa.o_value), 0);
      chk("rst_busy", int'(ifa.o_busy), 0);
      chk("rst_exp", int'(ifa.o_expired), 0);
      rst_n = 1'b1;
      armed = 1'b1;
      cyc();

      // one-shot 5 -> 0
      load_a(5);
      chk("t1_loaded", int'(ifa.o_value), 5);
      start_a();
      chk("t1_busy", int'(ifa.o_busy), 1);
      for (int i = 4; i >= 0; i--) begin
         cyc();
         chk("t1_value", int'(ifa.o_value), i);
      end
      chk("t1_exp", int'(ifa.o_expired), 1);
      chk("t1_idle", int'(ifa.o_busy), 0);
      cyc();
      chk("t1_exp_drop", int'(ifa.o_expired), 0);

      // periodic 3
      ifa.i_periodic = 1'b1;
      load_a(3);
      start_a();
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("t2_value", int'(ifa.o_value), 2 - (i % 3) + ((i % 3 == 2) ? 3 : 0));
         chk("t2_exp", int'(ifa.o_expired), (i % 3 == 2) ? 1 : 0);
         chk("t2_busy", int'(ifa.o_busy), 1);
      end

      // periodic reload 1 holds expiry high
      load_a(1);
      start_a();
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("rel1_exp", int'(ifa.o_expired), 1);
         chk("rel1_value", int'(ifa.o_value), 1);
      end
      ifa.i_periodic = 1'b0;

      // pause / resume
      load_a(6);
      start_a();
      repeat (2) cyc();
      chk("t3_at4", int'(ifa.o_value), 4);
      ifa.i_stop = 1'b1;
      cyc();
      ifa.i_stop = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("t3_hold", int'(ifa.o_value), 4);
      end
      chk("t3_hold_busy", int'(ifa.o_busy), 0);
      ifa.i_stop = 1'b1;
      ifa.i_start = 1'b1;
      cyc();
      ifa.i_stop = 1'b0;
      ifa.i_start = 1'b0;
      chk("t6_hold_ss", int'(ifa.o_busy), 0);
      start_a();
      chk("t3_resume", int'(ifa.o_busy), 1);
      repeat (3) cyc();
      chk("t3_noexp", int'(ifa.o_expired), 0);
      cyc();
      chk("t3_exp", int'(ifa.o_expired), 1);

      // abort by load
      load_a(9);
      start_a();
      repeat (7) cyc();
      chk("t4_at2", int'(ifa.o_value), 2);
      load_a(200);
      chk("t4_value", int'(ifa.o_value), 200);
      chk("t4_idle", int'(ifa.o_busy), 0);
      chk("t4_noexp", int'(ifa.o_expired), 0);
      load_a(0);
      start_a();
      chk("t4_zero_idle", int'(ifa.o_busy), 0);

      // load on the expiry edge suppresses the pulse
      load_a(2);
      start_a();
      cyc();
      load_a(7);
      chk("ldexp_noexp", int'(ifa.o_expired), 0);
      chk("ldexp_value", int'(ifa.o_value), 7);

      // start+stop in IDLE
      ifa.i_stop = 1'b1;
      ifa.i_start = 1'b1;
      cyc();
      ifa.i_stop = 1'b0;
      ifa.i_start = 1'b0;
      chk("t6_idle_ss", int'(ifa.o_busy), 0);

      // clamp and prescale on instance b
      load_b(127);
      chk("t5_clamp", int'(ifb.o_value), 100);
      load_b(2);
      start_b();
      repeat (4) cyc();
      chk("t5_first_dec", int'(ifb.o_value), 1);
      repeat (3) cyc();
      chk("t5_noexp7", int'(ifb.o_expired), 0);
      cyc();
      chk("t5_exp8", int'(ifb.o_expired), 1);
      chk("t5_idle", int'(ifb.o_busy), 0);

      // reset mid-run
      load_a(5);
      start_a();
      load_b(50);
      start_b();
      cyc();
      rst_n = 1'b0;
      cyc();
      chk("t6_rst_value", int'(ifa.o_value), 0);
      chk("t6_rst_busy", int'(ifa.o_busy), 0);
      chk("t6_rst_exp", int'(ifa.o_expired), 0);
      chk("t6_rst_b", int'(ifb.o_value), 0);
      rst_n = 1'b1;
      repeat (2) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
